// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the writeback arbiter.
package wb_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned XLEN   = 32;

   typedef struct packed {
      logic              valid;
      logic              kill;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_ll_entry_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Long-latency result FIFO: storage, kill-by-destination, head pop and
// pending-destination lookup for decode.
module wb_ll_fifo
   import wb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic              push_kill,
   input  logic [REG_AW-1:0] push_rd,
   input  logic [XLEN-1:0]   push_data,
   input  logic              kill_en,
   input  logic [REG_AW-1:0] kill_rd,
   input  logic              pop,
   input  logic [REG_AW-1:0] chk_addr1,
   input  logic [REG_AW-1:0] chk_addr2,
   output logic              full,
   output logic              empty,
   output logic              head_kill,
   output logic [REG_AW-1:0] head_rd,
   output logic [XLEN-1:0]   head_data,
   output logic              pend_hit1,
   output logic              pend_hit2
);

   localparam int unsigned PtrW = ptr_width(Depth);
   localparam int unsigned CntW = PtrW + 1;

   wb_ll_entry_t    entries_q [Depth];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;

   // Pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < Depth; i++) entries_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < Depth; i++) begin
            if (kill_en && entries_q[i].valid && (entries_q[i].rd == kill_rd)) begin
               entries_q[i].kill <= 1'b1;
            end
         end
         if (pop) begin
            entries_q[rptr_q].valid <= 1'b0;
            rptr_q                  <= rptr_q + PtrW'(1);
         end
         if (push) begin
            entries_q[wptr_q] <= '{valid: 1'b1, kill: push_kill, rd: push_rd, data: push_data};
            wptr_q            <= wptr_q + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;
         endcase
      end
   end

   assign full      = (count_q == CntW'(Depth));
   assign empty     = (count_q == '0);
   assign head_kill = entries_q[rptr_q].kill;
   assign head_rd   = entries_q[rptr_q].rd;
   assign head_data = entries_q[rptr_q].data;

   always_comb begin
      pend_hit1 = 1'b0;
      pend_hit2 = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (entries_q[i].valid && !entries_q[i].kill) begin
            if ((chk_addr1 != '0) && (entries_q[i].rd == chk_addr1)) pend_hit1 = 1'b1;
            if ((chk_addr2 != '0) && (entries_q[i].rd == chk_addr2)) pend_hit2 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_writeback_arb.sv
// Register-file writeback arbiter: pipeline results win, long-latency results queue.
// Optional WB_LL_BYPASS_EN writes an LL result straight through when nothing competes.
module wb_writeback_arb
   import wb_pkg::*;
#(
   parameter int unsigned LL_DEPTH   = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              pipe_wb_en,
   input  logic [REG_AW-1:0] pipe_wb_rd,
   input  logic [XLEN-1:0]   pipe_wb_data,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [REG_AW-1:0] ll_rd,
   input  logic [XLEN-1:0]   ll_data,
   input  logic [REG_AW-1:0] chk_addr1,
   input  logic [REG_AW-1:0] chk_addr2,
   output logic              pend_hit1,
   output logic              pend_hit2,
   output logic              stall_req,
   output logic              w_regs_en,
   output logic [REG_AW-1:0] w_regs_addr,
   output logic [XLEN-1:0]   w_regs_data
);

   localparam int unsigned StW = $clog2(STARVE_MAX + 1);

   logic              pipe_wr, ll_accept, bypass, fifo_push, push_kill;
   logic              pop, write_ll, blocked;
   logic              fifo_full, fifo_empty, head_kill;
   logic [REG_AW-1:0] head_rd;
   logic [XLEN-1:0]   head_data;
   logic [StW-1:0]    starve_q, starve_d;
   logic              en_q, en_d;
   logic [REG_AW-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   data_q, data_d;

   assign ll_ready  = !fifo_full;
   assign pipe_wr   = pipe_wb_en && (pipe_wb_rd != '0);
   // rd=0 results complete the handshake but are dropped here.
   assign ll_accept = ll_valid && ll_ready && (ll_rd != '0);

`ifdef WB_LL_BYPASS_EN
   assign bypass = ll_accept && fifo_empty && !pipe_wr;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push = ll_accept && !bypass;
   assign push_kill = pipe_wr && (ll_rd == pipe_wb_rd);
   // Killed heads retire silently even while the pipeline owns the port.
   assign pop       = !fifo_empty && (head_kill || !pipe_wr);
   assign write_ll  = pop && !head_kill;
   assign blocked   = !fifo_empty && !head_kill && pipe_wr;

   wb_ll_fifo #(
      .Depth (LL_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_kill (push_kill),
      .push_rd   (ll_rd),
      .push_data (ll_data),
      .kill_en   (pipe_wr),
      .kill_rd   (pipe_wb_rd),
      .pop       (pop),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_kill (head_kill),
      .head_rd   (head_rd),
      .head_data (head_data),
      .pend_hit1 (pend_hit1),
      .pend_hit2 (pend_hit2)
   );

   always_comb begin
      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (blocked && (starve_q != StW'(STARVE_MAX))) begin
         starve_d = starve_q + StW'(1);
      end
   end

   always_comb begin
      en_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (pipe_wr) begin
         en_d   = 1'b1;
         addr_d = pipe_wb_rd;
         data_d = pipe_wb_data;
      end else if (write_ll) begin
         en_d   = 1'b1;
         addr_d = head_rd;
         data_d = head_data;
      end else if (bypass) begin
         en_d   = 1'b1;
         addr_d = ll_rd;
         data_d = ll_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         starve_q <= '0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         starve_q <= starve_d;
         en_q     <= en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign stall_req   = (starve_q == StW'(STARVE_MAX));
   assign w_regs_en   = en_q;
   assign w_regs_addr = addr_q;
   assign w_regs_data = data_q;

endmodule

// File: tb/tb_wb_writeback_arb.sv
// Directed bench for wb_writeback_arb with a write scoreboard.
module tb_wb_writeback_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pipe_wb_en;
   logic [4:0]  pipe_wb_rd;
   logic [31:0] pipe_wb_data;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic [4:0]  chk_addr1, chk_addr2;
   logic        pend_hit1, pend_hit2, stall_req;
   logic        w_regs_en;
   logic [4:0]  w_regs_addr;
   logic [31:0] w_regs_data;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb[$];

   wb_writeback_arb #(
      .LL_DEPTH   (2),
      .STARVE_MAX (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .pipe_wb_en   (pipe_wb_en),
      .pipe_wb_rd   (pipe_wb_rd),
      .pipe_wb_data (pipe_wb_data),
      .ll_valid     (ll_valid),
      .ll_ready     (ll_ready),
      .ll_rd        (ll_rd),
      .ll_data      (ll_data),
      .chk_addr1    (chk_addr1),
      .chk_addr2    (chk_addr2),
      .pend_hit1    (pend_hit1),
      .pend_hit2    (pend_hit2),
      .stall_req    (stall_req),
      .w_regs_en    (w_regs_en),
      .w_regs_addr  (w_regs_addr),
      .w_regs_data  (w_regs_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
      pipe_wb_en   = 1'b1;
      pipe_wb_rd   = rd;
      pipe_wb_data = data;
      sb.push_back({rd, data});
   endtask

   task automatic ll(input logic [4:0] rd, input logic [31:0] data);
      ll_valid = 1'b1;
      ll_rd    = rd;
      ll_data  = data;
   endtask

   task automatic idle();
      pipe_wb_en = 1'b0;
      ll_valid   = 1'b0;
   endtask

   // Every register-file write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [36:0] exp_wr;
      logic        have;
      if (rstn === 1'b1 && w_regs_en === 1'b1) begin
         have   = (sb.size() > 0);
         exp_wr = have ? sb.pop_front() : '0;
         total++;
         assert (have && ({w_regs_addr, w_regs_data} === exp_wr)) else begin
            bad++;
            $error("FAIL sb_write observed=0x%0h expected=0x%0h have_expect=%0d",
                   {w_regs_addr, w_regs_data}, exp_wr, have);
         end
      end
   end

   initial begin
      rstn = 1'b0;
      pipe_wb_en = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
      ll_valid = 0; ll_rd = 0; ll_data = 0;
      chk_addr1 = 0; chk_addr2 = 0;
      #3;
      chk("rst_en", w_regs_en, 0);
      chk("rst_addr", w_regs_addr, 0);
      chk("rst_data", w_regs_data, 0);
      chk("rst_stall", stall_req, 0);
      step(); step();
      rstn = 1'b1;
      step();
      chk("rel_en", w_regs_en, 0);
      chk("rel_ready", ll_ready, 1);
      chk("rel_stall", stall_req, 0);

      // 1: pipe write appears next cycle for one cycle only
      pipe(5, 32'h11);
      step();
      chk("p_en", w_regs_en, 1);
      chk("p_addr", w_regs_addr, 5);
      chk("p_data", w_regs_data, 32'h11);
      idle();
      step();
      chk("p_en_drop", w_regs_en, 0);
      chk("p_addr_hold", w_regs_addr, 5);

      // 2: single LL result on an idle pipe
      ll(3, 32'hAB);
      chk_addr1 = 3;
      sb.push_back({5'd3, 32'hAB});
      step();
      idle();
`ifdef WB_LL_BYPASS_EN
      chk("ll_byp_en", w_regs_en, 1);
`else
      chk("ll_pend", pend_hit1, 1);
      chk("ll_en_n1", w_regs_en, 0);
      step();
      chk("ll_en_n2", w_regs_en, 1);
`endif
      chk("ll_addr", w_regs_addr, 3);
      chk("ll_data", w_regs_data, 32'hAB);
      chk("ll_pend_clr", pend_hit1, 0);
      step();

      // 3: continuous pipe writes fill the FIFO and starve it
      chk_addr2 = 21;
      pipe(10, 32'h100); ll(20, 32'hA0);
      chk("s_ready0", ll_ready, 1);
      step();
      pipe(11, 32'h101); ll(21, 32'hA1);
      chk("s_ready1", ll_ready, 1);
      step();
      ll_valid = 1'b0;
      chk("s_full", ll_ready, 0);
      chk("s_pend2", pend_hit2, 1);
      chk("s_stall_b", stall_req, 0);
      pipe(12, 32'h102); step();
      chk("s_stall_c", stall_req, 0);
      pipe(13, 32'h103); step();
      chk("s_stall_d", stall_req, 0);
      pipe(14, 32'h104); step();
      chk("s_stall_e", stall_req, 1);
      pipe(15, 32'h105); step();
      chk("s_stall_sat", stall_req, 1);
      chk("s_full2", ll_ready, 0);
      idle();
      sb.push_back({5'd20, 32'hA0});
      sb.push_back({5'd21, 32'hA1});
      step();
      chk("s_stall_clr", stall_req, 0);
      chk("s_drain_addr", w_regs_addr, 20);
      chk("s_ready_back", ll_ready, 1);
      step();
      chk("s_drain2_addr", w_regs_addr, 21);
      chk("s_pend2_clr", pend_hit2, 0);
      step();
      chk("s_idle_en", w_regs_en, 0);

      // 4: queued entry killed by a younger pipe write
      chk_addr1 = 7;
      pipe(16, 32'h116); ll(7, 32'h1);
      step();
      ll_valid = 1'b0;
      chk("k_pend", pend_hit1, 1);
      pipe(7, 32'h2);
      step();
      idle();
      chk("k_pend_drop", pend_hit1, 0);
      chk("k_data", w_regs_data, 32'h2);
      step();
      chk("k_silent", w_regs_en, 0);
      step();
      chk("k_silent2", w_regs_en, 0);

      // 5: same-cycle collision and rd=0 discard
      chk_addr1 = 9;
      pipe(9, 32'h55); ll(9, 32'h99);
      step();
      idle();
      chk("c_pend", pend_hit1, 0);
      chk("c_data", w_regs_data, 32'h55);
      step();
      chk("c_silent", w_regs_en, 0);
      ll(0, 32'hDEAD);
      chk_addr2 = 0;
      chk("z_ready", ll_ready, 1);
      step();
      idle();
      chk("z_en", w_regs_en, 0);
      chk("z_pend2", pend_hit2, 0);
      step();
      chk("z_en2", w_regs_en, 0);

      // 6: reset with two entries queued
      chk_addr1 = 22;
      pipe(17, 32'h117); ll(22, 32'hB2);
      step();
      pipe(18, 32'h118); ll(23, 32'hB3);
      step();
      ll_valid = 1'b0;
      chk("r_full", ll_ready, 0);
      chk("r_pend", pend_hit1, 1);
      pipe(19, 32'h119);
      step();
      idle();
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("r_en", w_regs_en, 0);
      chk("r_addr", w_regs_addr, 0);
      chk("r_data", w_regs_data, 0);
      chk("r_stall", stall_req, 0);
      chk("r_pend_clr", pend_hit1, 0);
      step(); step();
      rstn = 1'b1;
      step();
      chk("r_ready", ll_ready, 1);
      for (int i = 0; i < 3; i++) begin
         chk("r_no_write", w_regs_en, 0);
         step();
      end

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
